// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer.
// Optional feature macro used by the sequencer: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam int WORD_W   = 32;
  localparam int HALF_W   = 16;
  localparam int BYTE_W   = 8;
  localparam int OFF_W    = 2;

  // Access size as encoded on req_size; encoding 3 is folded onto WORD.
  typedef enum logic [1:0] {
    WORD = 2'd0,
    BYTE = 2'd1,
    HALF = 2'd2
  } lsu_size_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MRG  = 3'd2,
    WR   = 3'd3,
    RSP  = 3'd4
  } lsu_state_t;

  // Map the raw size field onto the three supported access sizes.
  function automatic lsu_size_t norm_size(input logic [1:0] s);
    case (s)
      2'd1:    return BYTE;
      2'd2:    return HALF;
      default: return WORD;
    endcase
  endfunction

  // A word must sit on a 4-byte boundary, a half on a 2-byte boundary.
  function automatic logic is_misaligned(input lsu_size_t sz, input logic [OFF_W-1:0] off);
    return ((sz == WORD) && (off != 2'd0)) || ((sz == HALF) && off[0]);
  endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Byte-lane steering: builds the store word for read-modify-write and the
// extended load result from one RAM word. Purely combinational.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] data,
  input  lsu_size_t         size,
  input  logic [OFF_W-1:0]  off,
  input  logic              is_unsigned,
  output logic [WORD_W-1:0] merged,
  output logic [WORD_W-1:0] load_ext
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  // Halves use off[1] only, so an odd half address lands on its aligned half.
  always_comb begin
    merged   = word;
    load_ext = word;
    byte_sel = word[{off, 3'b000} +: BYTE_W];
    half_sel = word[{off[1], 4'b0000} +: HALF_W];
    case (size)
      BYTE: begin
        merged[{off, 3'b000} +: BYTE_W] = data[BYTE_W-1:0];
        load_ext = {{(WORD_W-BYTE_W){~is_unsigned & byte_sel[BYTE_W-1]}}, byte_sel};
      end
      HALF: begin
        merged[{off[1], 4'b0000} +: HALF_W] = data[HALF_W-1:0];
        load_ext = {{(WORD_W-HALF_W){~is_unsigned & half_sel[HALF_W-1]}}, half_sel};
      end
      default: begin
        merged   = data;
        load_ext = word;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Multi-cycle load/store sequencer in front of a synchronous word RAM.
// Sub-word stores run as read-modify-write so the RAM needs one write enable.
// Macro LSU_MISALIGN_TRAP_EN: misaligned word/half accesses skip the RAM and
// complete with rsp_err set; without it they are aligned down silently.
// Handshake: a request transfers on a rising edge with req_valid && req_ready;
// req_ready is high only in IDLE and request inputs are ignored elsewhere.
// rsp_valid is a single-cycle pulse with no backpressure.
module lsu_mem_sequencer
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output lsu_state_t        dbg_state
);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  lsu_size_t         size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] merge_q, merge_d;

  logic              req_misal;
  logic [WORD_W-1:0] lane_merged;
  logic [WORD_W-1:0] lane_load;

  lsu_lane_merge u_lane (
    .word        (mem_rdata),
    .data        (wdata_q),
    .size        (size_q),
    .off         (addr_q[OFF_W-1:0]),
    .is_unsigned (uns_q),
    .merged      (lane_merged),
    .load_ext    (lane_load)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q, err_d;

  assign req_misal = is_misaligned(norm_size(req_size), req_addr[OFF_W-1:0]);

  // Remember whether the accepted request trapped, for the response cycle.
  always_comb begin
    err_d = err_q;
    if ((state_q == IDLE) && req_valid) err_d = req_misal;
  end

  // Trap flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign rsp_err = (state_q == RSP) && err_q;
`else
  assign req_misal = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // State, capture and merge registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= WORD;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
    end
  end

  // Next state, request capture and output decode from the state register.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    merge_d   = merge_q;
    req_ready = (state_q == IDLE);
    mem_re    = (state_q == RD);
    mem_we    = (state_q == WR);
    rsp_valid = (state_q == RSP);
    mem_addr  = addr_q[ADDR_W-1:OFF_W];
    mem_wdata = '0;
    rsp_rdata = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = norm_size(req_size);
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_misal)                                  state_d = RSP;
          else if (req_we && (norm_size(req_size) == WORD)) state_d = WR;
          else                                            state_d = RD;
        end
      end
      RD:  state_d = we_q ? MRG : RSP;
      MRG: begin
        merge_d = lane_merged;
        state_d = WR;
      end
      WR: begin
        mem_wdata = (size_q == WORD) ? wdata_q : merge_q;
        state_d   = RSP;
      end
      RSP: begin
        if (!we_q && !rsp_err) rsp_rdata = lane_load;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Self-checking bench for lsu_mem_sequencer: directed cases, randomized
// accesses against a byte-level reference memory, back-to-back and
// reset-during-RMW scenarios.
module tb_lsu_mem_sequencer;
  import lsu_pkg::*;

  localparam int ADDR_W = 8;
  localparam int NWORDS = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_re, mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = 32'h0;
  lsu_state_t        dbg_state;

  lsu_mem_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .dbg_state    (dbg_state)
  );

  // Synchronous RAM the sequencer drives; not cleared by reset.
  logic [31:0] ram [NWORDS];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // ---------------- scoreboard / reference model ----------------
  logic [31:0] ref_mem [NWORDS];
  logic [31:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  function automatic int bytes_of(input logic [1:0] s);
    if (s == 2'd1) return 1;
    if (s == 2'd2) return 2;
    return 4;
  endfunction

  function automatic int base_of(input int nbytes, input logic [1:0] off);
    if (nbytes == 1) return int'(off);
    if (nbytes == 2) return int'(off) & 2;
    return 0;
  endfunction

  function automatic logic model_misal(input int nbytes, input logic [1:0] off);
    if (!TRAP) return 1'b0;
    return (nbytes == 4 && off != 2'd0) || (nbytes == 2 && off[0]);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input int nbytes,
                                             input logic [1:0] off, input logic uns);
    logic [31:0] v, mask;
    if (nbytes == 4) return w;
    mask = (32'd1 << (8 * nbytes)) - 32'd1;
    v = (w >> (8 * base_of(nbytes, off))) & mask;
    if (!uns && v[8 * nbytes - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] d,
                                              input int nbytes, input logic [1:0] off);
    logic [31:0] r;
    int b;
    r = w;
    b = base_of(nbytes, off);
    for (int i = 0; i < nbytes; i++) r[8 * (b + i) +: 8] = d[8 * i +: 8];
    return r;
  endfunction

  // Strobes and the response pulse must never overlap.
  always @(negedge clk) begin
    if (!reset) begin
      tests_run++;
      if ((mem_re && mem_we) || (mem_re && rsp_valid) || (mem_we && rsp_valid)) begin
        tests_failed++;
        $display("FAIL strobe_overlap: got re=%0b we=%0b rsp=%0b expected at most one", mem_re, mem_we, rsp_valid);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [7:0] addr, input logic [31:0] wdata, input string tag);
    int nb, w, cyc, n, re_n, we_n, exp_lat, exp_re_n, exp_we_n;
    logic mis;
    logic [31:0] exp_new, got_wdata, exp_rd;
    nb  = bytes_of(size);
    w   = int'(addr[7:2]);
    mis = model_misal(nb, addr[1:0]);
    exp_new = model_store(ref_mem[w], wdata, nb, addr[1:0]);
    exp_rd  = (we || mis) ? 32'h0 : model_load(ref_mem[w], nb, addr[1:0], uns);
    exp_q.push_back(exp_rd);
    if (mis)           begin exp_lat = 1; exp_re_n = 0; exp_we_n = 0; end
    else if (!we)      begin exp_lat = 2; exp_re_n = 1; exp_we_n = 0; end
    else if (nb == 4)  begin exp_lat = 2; exp_re_n = 0; exp_we_n = 1; end
    else               begin exp_lat = 4; exp_re_n = 1; exp_we_n = 1; end

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    tests_run++;
    if (!req_ready) begin
      tests_failed++;
      $display("FAIL %s accept: got req_ready=0 expected 1 within 20 cycles", tag);
      req_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(negedge clk);
    // Scramble request inputs; the sequencer must ignore them while busy.
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_addr = 8'($urandom); req_wdata = $urandom; req_unsigned = 1'($urandom);
    cyc = 1; re_n = 0; we_n = 0; got_wdata = 32'h0;
    while (!rsp_valid && cyc < 10) begin
      tests_run++;
      if (req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s ready_busy: got %b expected 0 at cycle %0d", tag, req_ready, cyc);
      end
      if (mem_re || mem_we) begin
        tests_run++;
        if (mem_addr !== 6'(w)) begin
          tests_failed++;
          $display("FAIL %s mem_addr: got %h expected %h", tag, mem_addr, 6'(w));
        end
      end
      if (mem_re) re_n++;
      if (mem_we) begin we_n++; got_wdata = mem_wdata; end
      @(negedge clk);
      cyc++;
    end
    tests_run += 6;
    if (cyc != exp_lat) begin
      tests_failed++; $display("FAIL %s latency: got %0d expected %0d", tag, cyc, exp_lat);
    end
    if (rsp_valid !== 1'b1) begin
      tests_failed++; $display("FAIL %s rsp_valid: got %b expected 1", tag, rsp_valid);
    end
    exp_rd = exp_q.pop_front();
    if (rsp_rdata !== exp_rd) begin
      tests_failed++; $display("FAIL %s rdata: got %h expected %h", tag, rsp_rdata, exp_rd);
    end
    if (rsp_err !== mis) begin
      tests_failed++; $display("FAIL %s err: got %b expected %b", tag, rsp_err, mis);
    end
    if (re_n != exp_re_n) begin
      tests_failed++; $display("FAIL %s re_count: got %0d expected %0d", tag, re_n, exp_re_n);
    end
    if (we_n != exp_we_n) begin
      tests_failed++; $display("FAIL %s we_count: got %0d expected %0d", tag, we_n, exp_we_n);
    end
    if (exp_we_n == 1 && we_n == 1) begin
      tests_run++;
      if (got_wdata !== exp_new) begin
        tests_failed++; $display("FAIL %s wdata: got %h expected %h", tag, got_wdata, exp_new);
      end
    end
    if (we && !mis) ref_mem[w] = exp_new;
    @(negedge clk);
    tests_run += 2;
    if (req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL %s ready_after: got %b expected 1", tag, req_ready);
    end
    if (ram[w] !== ref_mem[w]) begin
      tests_failed++; $display("FAIL %s ram_word: got %h expected %h", tag, ram[w], ref_mem[w]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    #3;
    tests_run += 9;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
    if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset rsp_valid: got %b expected 0", rsp_valid); end
    if (rsp_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset rsp_rdata: got %h expected 0", rsp_rdata); end
    if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset rsp_err: got %b expected 0", rsp_err); end
    if (mem_re !== 1'b0) begin tests_failed++; $display("FAIL reset mem_re: got %b expected 0", mem_re); end
    if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset mem_we: got %b expected 0", mem_we); end
    if (mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL reset mem_wdata: got %h expected 0", mem_wdata); end
    if (mem_addr !== 6'h0) begin tests_failed++; $display("FAIL reset mem_addr: got %h expected 0", mem_addr); end
    if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL reset state: got %0d expected %0d", dbg_state, IDLE); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    ram[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;
    do_req(1'b0, 2'd0, 1'b0, 8'h10, 32'h0, "lw_0x10");
    do_req(1'b0, 2'd1, 1'b0, 8'h13, 32'h0, "lb_0x13");
    do_req(1'b0, 2'd1, 1'b1, 8'h13, 32'h0, "lbu_0x13");
    do_req(1'b0, 2'd2, 1'b0, 8'h12, 32'h0, "lh_0x12");
    do_req(1'b0, 2'd2, 1'b1, 8'h10, 32'h0, "lhu_0x10");
    do_req(1'b1, 2'd1, 1'b0, 8'h11, 32'h000000CC, "sb_0x11");
    tests_run++;
    if (ram[4] !== 32'h8899CCBB) begin
      tests_failed++; $display("FAIL sb_result: got %h expected %h", ram[4], 32'h8899CCBB);
    end
    do_req(1'b0, 2'd3, 1'b0, 8'h10, 32'h0, "lw_size3");
  endtask

  task automatic test_misalign();
    do_req(1'b0, 2'd0, 1'b0, 8'h11, 32'h0, "lw_0x11");
    do_req(1'b0, 2'd2, 1'b0, 8'h13, 32'h0, "lh_0x13");
    do_req(1'b1, 2'd0, 1'b0, 8'h16, 32'h12345678, "sw_0x16");
    do_req(1'b1, 2'd2, 1'b0, 8'h19, 32'h0000A55A, "sh_0x19");
  endtask

  task automatic test_back_to_back();
    ram[8] = 32'h0; ref_mem[8] = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 8'h20; req_wdata = 32'hDEADBEEF;
    @(negedge clk);  // one cycle after acceptance: WR
    tests_run += 3;
    if (mem_we !== 1'b1) begin tests_failed++; $display("FAIL b2b sw_we: got %b expected 1", mem_we); end
    if (mem_re !== 1'b0) begin tests_failed++; $display("FAIL b2b sw_re: got %b expected 0", mem_re); end
    if (mem_wdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL b2b sw_wdata: got %h expected DEADBEEF", mem_wdata); end
    req_we = 1'b0;  // next request waits behind the busy sequencer
    @(negedge clk);
    tests_run++;
    if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b sw_rsp: got %b expected 1", rsp_valid); end
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b ready: got %b expected 1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    tests_run += 2;
    if (mem_re !== 1'b1) begin tests_failed++; $display("FAIL b2b lw_re: got %b expected 1", mem_re); end
    if (mem_addr !== 6'h08) begin tests_failed++; $display("FAIL b2b lw_addr: got %h expected 08", mem_addr); end
    @(negedge clk);
    tests_run += 2;
    if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b lw_rsp: got %b expected 1", rsp_valid); end
    if (rsp_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL b2b lw_rdata: got %h expected DEADBEEF", rsp_rdata); end
    ref_mem[8] = 32'hDEADBEEF;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < NWORDS; i++) begin
      ram[i] = $urandom; ref_mem[i] = ram[i];
    end
    for (int k = 0; k < 150; k++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), $urandom, "rand");
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] old;
    int n;
    old = 32'h13579BDF; ram[9] = old; ref_mem[9] = old;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 8'h26; req_wdata = 32'h0000BEEF;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);  // RD
    req_valid = 1'b0;
    @(negedge clk);  // MRG
    tests_run++;
    if (dbg_state !== MRG) begin tests_failed++; $display("FAIL rst_mid pre_state: got %0d expected %0d", dbg_state, MRG); end
    #1 reset = 1'b1;
    #1;
    tests_run += 4;
    if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL rst_mid state: got %0d expected %0d", dbg_state, IDLE); end
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_mid ready: got %b expected 1", req_ready); end
    if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL rst_mid we: got %b expected 0", mem_we); end
    if (mem_re !== 1'b0) begin tests_failed++; $display("FAIL rst_mid re: got %b expected 0", mem_re); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests_run++;
      if (mem_we !== 1'b0 || rsp_valid !== 1'b0) begin
        tests_failed++; $display("FAIL rst_mid quiet: got we=%b rsp=%b expected 0 0", mem_we, rsp_valid);
      end
    end
    tests_run++;
    if (ram[9] !== old) begin tests_failed++; $display("FAIL rst_mid ram: got %h expected %h", ram[9], old); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_misalign();
    test_back_to_back();
    test_random();
    test_reset_mid();
    do_req(1'b0, 2'd1, 1'b1, 8'h27, 32'h0, "post_reset_lbu");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
